// File: rtl/weight_ram_writer.sv
// rtl/weight_ram_writer.sv - packs streamed weight elements into 9-element words and writes 4-word blocks to the weight RAM
// Optional feature macro: WEIGHT_WR_CHECKSUM_EN builds the running element checksum.
module weight_ram_writer #(
    parameter int         DATA_LEN     = 8,
    parameter int         BASE_STRIDE  = 32,
    parameter int         PHASE_STRIDE = 4,
    parameter logic [3:0] LAYER0       = 4'd0,
    parameter logic [3:0] LAYER1       = 4'd1,
    parameter logic [3:0] LAYER2       = 4'd2,
    parameter logic [3:0] LAYER3       = 4'd3,
    parameter logic [3:0] AFFINE       = 4'd4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [3:0]              cs,
    input  logic [2:0]              phase,
    input  logic                    in_valid,
    input  logic [DATA_LEN-1:0]     in_data,
    output logic                    in_ready,
    output logic                    ram_we,
    output logic [7:0]              ram_addr,
    output logic [9*DATA_LEN-1:0]   ram_wdata,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [15:0]             checksum
);

    localparam int WORD_W = 9 * DATA_LEN;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t            state;
    logic [7:0]        base;
    logic [1:0]        wcnt;
    logic [3:0]        ecnt;
    logic [WORD_W-1:0] word_buf;
    logic [WORD_W-1:0] word_next;
    logic              cs_mapped;
    logic [2:0]        region;
    logic [7:0]        start_base;
    logic              accept_start;
    logic              take;

    always_comb begin
        cs_mapped = 1'b1;
        region    = 3'd0;
        if (cs == LAYER0)      region = 3'd0;
        else if (cs == LAYER1) region = 3'd1;
        else if (cs == LAYER2) region = 3'd2;
        else if (cs == LAYER3) region = 3'd3;
        else if (cs == AFFINE) region = 3'd4;
        else                   cs_mapped = 1'b0;
        start_base = 8'(32'(region) * BASE_STRIDE + 32'(phase) * PHASE_STRIDE);
    end

    assign accept_start = (state == IDLE) && start && cs_mapped;
    assign take         = (state == FILL) && in_valid && in_ready;

    // Slot ecnt of the word under construction receives the current element.
    always_comb begin
        word_next = word_buf;
        for (int i = 0; i < 9; i++) begin
            if (ecnt == 4'(i)) word_next[i*DATA_LEN +: DATA_LEN] = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            base      <= 8'd0;
            wcnt      <= 2'd0;
            ecnt      <= 4'd0;
            word_buf  <= '0;
            in_ready  <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= 8'd0;
            ram_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            ram_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_start) begin
                        base     <= start_base;
                        wcnt     <= 2'd0;
                        ecnt     <= 4'd0;
                        word_buf <= '0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                        state    <= FILL;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                FILL: begin
                    if (take) begin
                        word_buf <= word_next;
                        if (ecnt == 4'd8) begin
                            ram_we    <= 1'b1;
                            ram_addr  <= base + {6'd0, wcnt};
                            ram_wdata <= word_next;
                            in_ready  <= 1'b0;
                            state     <= WRITE;
                        end else begin
                            ecnt <= ecnt + 4'd1;
                        end
                    end
                end
                WRITE: begin
                    if (wcnt == 2'd3) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        wcnt     <= wcnt + 2'd1;
                        ecnt     <= 4'd0;
                        in_ready <= 1'b1;
                        state    <= FILL;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef WEIGHT_WR_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst)               checksum <= 16'd0;
        else if (accept_start) checksum <= 16'd0;
        else if (take)         checksum <= checksum + 16'(in_data);
    end
`else
    assign checksum = 16'd0;
`endif

endmodule
